all_stubs_paged: RTL and testbench
==================================

// Module: all_stubs_paged
// PURPOSE
//  Per-BX paged stub store, parametrised successor of the two-copy all-stubs memory.
//  Writes the incoming stub stream into one page per bunch crossing. Serves N_RD
//  independent read ports, each returning the stub and the entry count of the page read.
//  Adds saturation with overflow reporting and start/done pipelining for downstream consumers.
// PARAMETERS
//  DATA_W  36  stub word width
//  ADDR_W  6   log2 entries per page; a page holds 2**ADDR_W stubs
//  PAGE_W  5   log2 number of BX pages; the page pointer wraps modulo 2**PAGE_W
//  N_RD    2   number of independent read ports, 1..4
//  TMUX    6   start->done delay in clk cycles, >=1
// PORTS
//  clk       in   1                    processing clock
//  reset     in   1                    synchronous, active-high
//  start     in   2                    [0] new-BX strobe; [1] pipelined reset
//  done      out  2                    start delayed by TMUX cycles
//  data_in   in   DATA_W               stub word
//  enable    in   1                    data_in valid this cycle
//  read_add  in   N_RD*(PAGE_W+ADDR_W) per port {page,entry}; port k in slice k
//  data_out  out  N_RD*DATA_W          per-port read data
//  nent_out  out  N_RD*(ADDR_W+1)      per-port entry count of the addressed page
//  overflow  out  1                    sticky: current page dropped at least one stub
//  ovf_cnt   out  16                   total dropped stubs, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset and start[1] have the same effect at the next edge:
//   - page pointer <- all ones
//   - write count <- 0
//   - every page count <- 0
//   - overflow, ovf_cnt, data_out, nent_out <- 0
//   - the done pipeline is flushed to 0
//  Memory contents are never cleared. Reset takes priority over start and enable.
//  start[0] edge: page <- page+1 (wraps 2**PAGE_W-1 -> 0); write count restarts; overflow <- 0.
//  Write on enable: word goes to {page, wcnt}, then wcnt <- wcnt+1.
//   - The first stub of a page is at entry 0; no off-by-one offset.
//  start[0] and enable in the same cycle: the stub belongs to the new page, at entry 0;
//   that page's count becomes 1.
//  Page count: the count of the current page is updated in the same cycle as each write.
//   It ranges 0..2**ADDR_W (ADDR_W+1 bits).
//  Full page (wcnt == 2**ADDR_W): the enable is dropped and nothing is written.
//   overflow <- 1; ovf_cnt increments unless already saturated.
//  Read ports are independent, with 2-cycle latency (address register plus output register).
//   nent_out is aligned to data_out with the same 2-cycle latency.
//  Read and write to the same address in the same cycle: the read returns the old contents.
//   There is no bypass.
//  A page reused after wrap keeps stale data beyond its new count.
//   Consumers must bound their reads by nent_out.
//  done: a shift register on start, TMUX stages long, cleared by reset.
// TESTING
//  T1: reset, then start[0] pulse, then 3 enables with data A,B,C.
//   -> page 0 entries 0..2 = A,B,C; read {0,1} gives B two cycles later; nent_out = 3.
//  T2: start[0] and enable together with data D.
//   -> D at entry 0 of the new page; count = 1.
//  T3: ADDR_W=2; 6 enables into one page.
//   -> entries 0..3 written; count = 4; overflow = 1; ovf_cnt = 2.
//   -> the next start[0] clears overflow; ovf_cnt stays 2.
//  T4: 33 start[0] pulses with PAGE_W=5.
//   -> page wraps 31 -> 0; writes land in page 0; its count restarts from 0.
//  T5: N_RD=2, both ports reading different pages while writes continue.
//   -> each port returns the correct word and count at latency 2.
//   -> same-address read/write returns old data.
//  T6: start[1] mid-page, after 5 writes.
//   -> next cycle: all counts 0, page all ones, done pipeline empty.
//   -> the next start[0] selects page 0.

Source files
------------

// File: rtl/all_stubs_paged.sv
// Paged stub store: one page per bunch crossing, N_RD independent 2-cycle read ports,
// per-page entry counts, saturating overflow reporting and a start->done delay line.
module all_stubs_paged #(
  parameter int DATA_W = 36,
  parameter int ADDR_W = 6,
  parameter int PAGE_W = 5,
  parameter int N_RD   = 2,
  parameter int TMUX   = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [1:0]                     start,
  output logic [1:0]                     done,
  input  logic [DATA_W-1:0]              data_in,
  input  logic                           enable,
  input  logic [N_RD*(PAGE_W+ADDR_W)-1:0] read_add,
  output logic [N_RD*DATA_W-1:0]         data_out,
  output logic [N_RD*(ADDR_W+1)-1:0]     nent_out,
  output logic                           overflow,
  output logic [15:0]                    ovf_cnt
);

  localparam int NPAGE = 1 << PAGE_W;
  localparam int RA_W  = PAGE_W + ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  // Write side is valid-only: enable qualifies data_in for one cycle, there is no
  // backpressure, and a word arriving at a full page is dropped and counted.
  logic                 clr;
  logic [PAGE_W-1:0]    page_q, wr_page;
  logic [CNT_W-1:0]     wcnt_q, wr_cnt;
  logic                 full, wr_en, drop;
  logic [DATA_W-1:0]    mem [NPAGE << ADDR_W];
  logic [CNT_W-1:0]     page_cnt [NPAGE];
  logic [RA_W-1:0]      ra_q [N_RD];
  logic [1:0]           done_sr [TMUX];

  assign clr     = reset | start[1];
  // A new-BX strobe redirects a same-cycle write to entry 0 of the next page.
  assign wr_page = start[0] ? page_q + PAGE_W'(1) : page_q;
  assign wr_cnt  = start[0] ? '0 : wcnt_q;
  assign full    = wr_cnt[ADDR_W];
  assign wr_en   = enable & ~full & ~clr;
  assign drop    = enable & full & ~clr;

  always_ff @(posedge clk) begin
    if (clr) begin
      page_q   <= '1;
      wcnt_q   <= '0;
      overflow <= 1'b0;
      ovf_cnt  <= '0;
      for (int i = 0; i < NPAGE; i++) page_cnt[i] <= '0;
    end else begin
      page_q <= wr_page;
      wcnt_q <= wr_en ? wr_cnt + CNT_W'(1) : wr_cnt;
      if (start[0] || wr_en) page_cnt[wr_page] <= wr_en ? wr_cnt + CNT_W'(1) : '0;
      if (drop) overflow <= 1'b1;
      else if (start[0]) overflow <= 1'b0;
      if (drop && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_page, wr_cnt[ADDR_W-1:0]}] <= data_in;
  end

  // Reads sample the array before this edge's write lands, so a colliding read sees old data.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_RD; k++) begin
      if (clr) begin
        ra_q[k]                       <= '0;
        data_out[k*DATA_W +: DATA_W]  <= '0;
        nent_out[k*CNT_W +: CNT_W]    <= '0;
      end else begin
        ra_q[k]                       <= read_add[k*RA_W +: RA_W];
        data_out[k*DATA_W +: DATA_W]  <= mem[ra_q[k]];
        nent_out[k*CNT_W +: CNT_W]    <= page_cnt[ra_q[k][RA_W-1 -: PAGE_W]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < TMUX; i++) done_sr[i] <= '0;
    end else begin
      done_sr[0] <= start;
      for (int i = 1; i < TMUX; i++) done_sr[i] <= done_sr[i-1];
    end
  end

  assign done = done_sr[TMUX-1];

endmodule

// File: tb/tb_all_stubs_paged.sv
// Directed bench for all_stubs_paged with 4-entry pages so overflow and wrap are cheap to reach.
module tb_all_stubs_paged;

  localparam int DATA_W = 36;
  localparam int ADDR_W = 2;
  localparam int PAGE_W = 5;
  localparam int N_RD   = 2;
  localparam int TMUX   = 4;
  localparam int RA_W   = PAGE_W + ADDR_W;
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [DATA_W-1:0] W_A = 36'h0AAAA0001;
  localparam logic [DATA_W-1:0] W_B = 36'h0BBBB0002;
  localparam logic [DATA_W-1:0] W_C = 36'h0CCCC0003;
  localparam logic [DATA_W-1:0] W_D = 36'h0DDDD0004;
  localparam logic [DATA_W-1:0] W_E = 36'h333330000;
  localparam logic [DATA_W-1:0] W_F = 36'h0FFFF0005;
  localparam logic [DATA_W-1:0] W_X = 36'h512340006;
  localparam logic [DATA_W-1:0] W_Y = 36'h656780007;
  localparam logic [DATA_W-1:0] W_Z = 36'h7ABC00000;
  localparam logic [DATA_W-1:0] W_G = 36'h8F00D0008;

  logic                   clk;
  logic                   reset;
  logic [1:0]             start;
  logic [1:0]             done;
  logic [DATA_W-1:0]      data_in;
  logic                   enable;
  logic [N_RD*RA_W-1:0]   read_add;
  logic [N_RD*DATA_W-1:0] data_out;
  logic [N_RD*CNT_W-1:0]  nent_out;
  logic                   overflow;
  logic [15:0]            ovf_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q[$];

  all_stubs_paged #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PAGE_W(PAGE_W), .N_RD(N_RD), .TMUX(TMUX)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .data_in(data_in), .enable(enable), .read_add(read_add),
    .data_out(data_out), .nent_out(nent_out),
    .overflow(overflow), .ovf_cnt(ovf_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int k, input logic [PAGE_W-1:0] pg, input logic [ADDR_W-1:0] ent);
    read_add[k*RA_W +: RA_W] = {pg, ent};
  endtask

  function automatic logic [DATA_W-1:0] rd_data(input int k);
    return data_out[k*DATA_W +: DATA_W];
  endfunction

  function automatic logic [CNT_W-1:0] rd_nent(input int k);
    return nent_out[k*CNT_W +: CNT_W];
  endfunction

  // Scoreboard check
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start = 2'b00; enable = 1'b0; data_in = '0; read_add = '0;
    tick(); tick();
    chk("rst_done", done, 2'b00);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_ovf_cnt", ovf_cnt, 16'd0);
    chk("rst_data", data_out, '0);
    chk("rst_nent", nent_out, '0);
    reset = 1'b0;

    // T1: new BX then A,B,C into page 0; done appears TMUX edges after start
    start = 2'b01; tick(); start = 2'b00;
    chk("t1_done_0", done, 2'b00);
    enable = 1'b1;
    data_in = W_A; tick();
    data_in = W_B; tick();
    chk("t1_done_early", done, 2'b00);
    data_in = W_C; tick();
    chk("t1_done_lat", done, 2'b01);
    enable = 1'b0;
    exp_q.push_back(W_A); exp_q.push_back(W_B); exp_q.push_back(W_C);
    set_rd(0, 5'd0, 2'd1); set_rd(1, 5'd0, 2'd2);
    tick();
    chk("t1_done_gone", done, 2'b00);
    tick();
    chk("t1_p0_data", rd_data(0), W_B);
    chk("t1_p1_data", rd_data(1), W_C);
    chk("t1_p0_nent", rd_nent(0), 3'd3);
    chk("t1_p1_nent", rd_nent(1), 3'd3);
    for (int i = 0; i < 3; i++) begin
      set_rd(0, 5'd0, 2'(i));
      tick(); tick();
      chk("t1_seq", rd_data(0), exp_q.pop_front());
    end

    // T2: start and enable together put D at entry 0 of page 1
    start = 2'b01; enable = 1'b1; data_in = W_D; tick();
    start = 2'b00; enable = 1'b0;
    set_rd(0, 5'd1, 2'd0); set_rd(1, 5'd0, 2'd0);
    tick(); tick();
    chk("t2_data", rd_data(0), W_D);
    chk("t2_nent", rd_nent(0), 3'd1);
    chk("t2_p1_data", rd_data(1), W_A);
    chk("t2_p1_nent", rd_nent(1), 3'd3);

    // T3: six writes into 4-entry page 2
    start = 2'b01; tick(); start = 2'b00;
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_in = W_E + DATA_W'(i);
      tick();
      if (i == 3) chk("t3_ovf_at_full", overflow, 1'b0);
      if (i == 4) begin
        chk("t3_ovf_first", overflow, 1'b1);
        chk("t3_cnt_first", ovf_cnt, 16'd1);
      end
    end
    enable = 1'b0;
    chk("t3_ovf", overflow, 1'b1);
    chk("t3_ovf_cnt", ovf_cnt, 16'd2);
    set_rd(0, 5'd2, 2'd3); set_rd(1, 5'd2, 2'd0);
    tick(); tick();
    chk("t3_last", rd_data(0), W_E + DATA_W'(3));
    chk("t3_first", rd_data(1), W_E);
    chk("t3_nent", rd_nent(0), 3'd4);
    start = 2'b01; tick(); start = 2'b00;
    chk("t3_ovf_clr", overflow, 1'b0);
    chk("t3_cnt_keep", ovf_cnt, 16'd2);

    // T4: walk from page 3 to 31, write F, then wrap to page 0
    repeat (28) begin
      start = 2'b01; tick();
    end
    start = 2'b00;
    enable = 1'b1; data_in = W_F; tick(); enable = 1'b0;
    start = 2'b01; tick(); start = 2'b00;
    set_rd(0, 5'd0, 2'd1); set_rd(1, 5'd31, 2'd0);
    tick(); tick();
    chk("t4_stale", rd_data(0), W_B);
    chk("t4_wrap_nent", rd_nent(0), 3'd0);
    chk("t4_p31_data", rd_data(1), W_F);
    chk("t4_p31_nent", rd_nent(1), 3'd1);

    // T5: port 0 collides with writes to page 0 while port 1 reads page 31
    set_rd(0, 5'd0, 2'd0);
    tick();
    enable = 1'b1; data_in = W_X; tick();
    chk("t5_rw_old", rd_data(0), W_A);
    chk("t5_p1_data", rd_data(1), W_F);
    data_in = W_Y; tick();
    chk("t5_rw_new", rd_data(0), W_X);
    enable = 1'b0; tick();
    chk("t5_nent", rd_nent(0), 3'd2);
    chk("t5_p1_nent", rd_nent(1), 3'd1);

    // T6: five writes into page 1, then pipelined reset
    start = 2'b01; enable = 1'b1; data_in = W_Z; tick();
    start = 2'b00;
    for (int i = 1; i < 5; i++) begin
      data_in = W_Z + DATA_W'(i);
      tick();
    end
    enable = 1'b0;
    chk("t6_ovf", overflow, 1'b1);
    chk("t6_ovf_cnt", ovf_cnt, 16'd3);
    start = 2'b11; tick(); start = 2'b00;
    chk("t6_done", done, 2'b00);
    chk("t6_ovf_clr", overflow, 1'b0);
    chk("t6_cnt_clr", ovf_cnt, 16'd0);
    chk("t6_data_clr", data_out, '0);
    chk("t6_nent_clr", nent_out, '0);
    set_rd(0, 5'd1, 2'd1); set_rd(1, 5'd2, 2'd0);
    tick(); tick();
    chk("t6_stale", rd_data(0), W_Z + DATA_W'(1));
    chk("t6_nent0", rd_nent(0), 3'd0);
    chk("t6_nent1", rd_nent(1), 3'd0);
    tick();
    chk("t6_done_empty", done, 2'b00);
    start = 2'b01; enable = 1'b1; data_in = W_G; tick();
    start = 2'b00; enable = 1'b0;
    set_rd(0, 5'd0, 2'd0); set_rd(1, 5'd0, 2'd1);
    tick(); tick();
    chk("t6_page0", rd_data(0), W_G);
    chk("t6_page0_nent", rd_nent(0), 3'd1);
    chk("t6_page0_stale", rd_data(1), W_Y);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
